// File: rtl/sevenseg_capture.sv
// sevenseg_capture: watches a multiplexed active-low 7-segment bus and
// rebuilds the hex nibble shown on each digit. A sample (pattern + select)
// must repeat for STABLE_CYCLES consecutive cycles before it is committed
// into a per-digit shadow entry. Changed shadows are presented as one word
// on a valid/ready interface.
module sevenseg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_value,
  output logic [NUM_DIGITS-1:0]   out_blank,
  output logic [NUM_DIGITS-1:0]   out_error
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {IDLE, PRESENT} state_t;

  logic [6:0]              prev_seg_reg;
  logic [NUM_DIGITS-1:0]   prev_dig_reg;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    dig_onehot, same_sample, commit;
  logic [3:0]              dec_value;
  logic                    dec_blank, dec_error;
  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0]   shadow_blank, shadow_error;
  logic [3:0]              sel_value;
  logic                    sel_blank, sel_error, entry_changed;
  logic                    dirty_reg;
  state_t                  state_reg, state_next;
  logic                    load_out;

  // Run tracking: a run restarts on any change of pattern or select and is
  // abandoned while the select is not one-hot. The counter saturates so a
  // run can only commit once.
  always_comb begin
    dig_onehot  = $onehot(dig_en);
    same_sample = (seg_n == prev_seg_reg) && (dig_en == prev_dig_reg);
    commit      = dig_onehot && same_sample && (cnt_reg == CNT_ARM);
    cnt_next    = cnt_reg;
    if (!dig_onehot)
      cnt_next = '0;
    else if (!same_sample)
      cnt_next = CNT_W'(1);
    else if (cnt_reg < CNT_MAX)
      cnt_next = cnt_reg + CNT_W'(1);
  end

  // Previous-sample and run-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_seg_reg <= '0;
      prev_dig_reg <= '0;
      cnt_reg      <= '0;
    end else begin
      prev_seg_reg <= seg_n;
      prev_dig_reg <= dig_en;
      cnt_reg      <= cnt_next;
    end
  end

  // Segment pattern decode; all-off is blank, anything unknown is an error.
  always_comb begin
    dec_value = 4'h0;
    dec_blank = 1'b0;
    dec_error = 1'b0;
    case (seg_n)
      7'h40: dec_value = 4'h0;
      7'h79: dec_value = 4'h1;
      7'h24: dec_value = 4'h2;
      7'h30: dec_value = 4'h3;
      7'h19: dec_value = 4'h4;
      7'h12: dec_value = 4'h5;
      7'h02: dec_value = 4'h6;
      7'h78: dec_value = 4'h7;
      7'h00: dec_value = 4'h8;
      7'h10: dec_value = 4'h9;
      7'h08: dec_value = 4'hA;
      7'h03: dec_value = 4'hB;
      7'h46: dec_value = 4'hC;
      7'h21: dec_value = 4'hD;
      7'h06: dec_value = 4'hE;
      7'h0E: dec_value = 4'hF;
      7'h7F: dec_blank = 1'b1;
      default: dec_error = 1'b1;
    endcase
  end

  // Per-digit shadow entries, written only by a commit addressed to them.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] value_reg;
      logic       blank_reg;
      logic       error_reg;

      // Shadow entry for this digit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          value_reg <= 4'h0;
          blank_reg <= 1'b1;
          error_reg <= 1'b0;
        end else if (commit && dig_en[gi]) begin
          value_reg <= dec_value;
          blank_reg <= dec_blank;
          error_reg <= dec_error;
        end
      end

      assign shadow_value[4*gi +: 4] = value_reg;
      assign shadow_blank[gi]        = blank_reg;
      assign shadow_error[gi]        = error_reg;
    end
  endgenerate

  // Pick the shadow entry of the selected digit (select is one-hot on commit).
  always_comb begin
    sel_value = 4'h0;
    sel_blank = 1'b0;
    sel_error = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_en[i]) begin
        sel_value = sel_value | shadow_value[4*i +: 4];
        sel_blank = sel_blank | shadow_blank[i];
        sel_error = sel_error | shadow_error[i];
      end
    end
    entry_changed = (sel_value != dec_value) || (sel_blank != dec_blank) ||
                    (sel_error != dec_error);
  end

  // Dirty flag: a changing commit sets it and wins over the clear from a copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dirty_reg <= 1'b0;
    else if (commit && entry_changed)
      dirty_reg <= 1'b1;
    else if (load_out)
      dirty_reg <= 1'b0;
  end

  // Output FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Output FSM next state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (dirty_reg) state_next = PRESENT;
      PRESENT: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output FSM outputs: valid while presenting, snapshot load from IDLE.
  always_comb begin
    out_valid = (state_reg == PRESENT);
    load_out  = (state_reg == IDLE) && dirty_reg;
  end

  // Presented word: snapshot of the shadows, frozen outside the IDLE copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_value <= '0;
      out_blank <= '1;
      out_error <= '0;
    end else if (load_out) begin
      out_value <= shadow_value;
      out_blank <= shadow_blank;
      out_error <= shadow_error;
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Testbench for sevenseg_capture: directed scenarios followed by random
// display traffic, all checked each cycle against a behavioural model of
// run lengths, shadow digits and the presented word.
module tb_sevenseg_capture;

  localparam int N = 4;
  localparam int S = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg_n;
  logic [N-1:0]  dig_en;
  logic          out_valid;
  logic          out_ready;
  logic [4*N-1:0] out_value;
  logic [N-1:0]  out_blank;
  logic [N-1:0]  out_error;

  int checks = 0;
  int failures = 0;

  sevenseg_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .dig_en(dig_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_blank(out_blank), .out_error(out_error)
  );

  always #5 clk = ~clk;

  // Glyph table indexed by hex value.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state.
  int         m_run;
  logic [6:0] m_pseg;
  logic [3:0] m_pdig;
  logic [3:0] m_sval [N];
  bit         m_sblank [N];
  bit         m_serr [N];
  bit         m_dirty, m_valid;
  logic [15:0] m_oval;
  logic [3:0]  m_oblank, m_oerr;

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void decode(input logic [6:0] s, output logic [3:0] v,
                                 output bit b, output bit e);
    v = 4'h0; b = 1'b0; e = 1'b1;
    if (s == 7'h7F) begin
      e = 1'b0; b = 1'b1;
    end
    for (int k = 0; k < 16; k++)
      if (glyph[k] == s) begin
        v = 4'(k); e = 1'b0;
      end
  endfunction

  function automatic void model_reset();
    m_run = 0; m_pseg = '0; m_pdig = '0;
    for (int k = 0; k < N; k++) begin
      m_sval[k] = 4'h0; m_sblank[k] = 1'b1; m_serr[k] = 1'b0;
    end
    m_dirty = 1'b0; m_valid = 1'b0;
    m_oval = '0; m_oblank = '1; m_oerr = '0;
  endfunction

  // One clock edge of the reference behaviour.
  function automatic void model_step(input logic [6:0] s, input logic [3:0] d, input logic r);
    logic [3:0] v;
    bit b, e;
    int idx;
    // Word presentation uses the shadows as they were before this edge.
    if (!m_valid) begin
      if (m_dirty) begin
        for (int k = 0; k < N; k++) begin
          m_oval[4*k +: 4] = m_sval[k];
          m_oblank[k] = m_sblank[k];
          m_oerr[k] = m_serr[k];
        end
        m_dirty = 1'b0;
        m_valid = 1'b1;
      end
    end else if (r) begin
      m_valid = 1'b0;
    end
    // Length of the current run of identical one-hot samples.
    if ($countones(d) != 1) m_run = 0;
    else if (s == m_pseg && d == m_pdig) m_run = m_run + 1;
    else m_run = 1;
    if (m_run == S) begin
      idx = 0;
      for (int k = 0; k < N; k++) if (d[k]) idx = k;
      decode(s, v, b, e);
      if (v != m_sval[idx] || b != m_sblank[idx] || e != m_serr[idx]) m_dirty = 1'b1;
      m_sval[idx] = v; m_sblank[idx] = b; m_serr[idx] = e;
    end
    m_pseg = s; m_pdig = d;
  endfunction

  task automatic compare_all(input string tag);
    ck({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    ck({tag, "_value"}, 32'(out_value), 32'(m_oval));
    ck({tag, "_blank"}, 32'(out_blank), 32'(m_oblank));
    ck({tag, "_error"}, 32'(out_error), 32'(m_oerr));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check at negedge.
  task automatic tick(input logic [6:0] s, input logic [3:0] d, input logic r, input string tag);
    seg_n = s; dig_en = d; out_ready = r;
    @(posedge clk);
    model_step(s, d, r);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] d, input logic r,
                      input int n, input string tag);
    for (int k = 0; k < n; k++) tick(s, d, r, tag);
    $display("hold %s seg_n=%02h dig_en=%b ready=%0d cycles=%0d valid=%0d value=%04h blank=%b error=%b",
             tag, s, d, r, n, out_valid, out_value, out_blank, out_error);
  endtask

  // Asynchronous reset applied between edges, checked before any clock edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    seg_n = 7'h7F; dig_en = '0; out_ready = 1'b0;
    #1;
    model_reset();
    ck({tag, "_rvalid"}, 32'(out_valid), 32'd0);
    ck({tag, "_rvalue"}, 32'(out_value), 32'h0);
    ck({tag, "_rblank"}, 32'(out_blank), 32'hF);
    ck({tag, "_rerror"}, 32'(out_error), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset %s", tag);
  endtask

  logic [6:0] rs;
  logic [3:0] rd;
  int         rl;

  initial begin
    rst_n = 1'b0; seg_n = 7'h7F; dig_en = '0; out_ready = 1'b0;
    @(negedge clk);
    do_reset("init");

    // Latency: value 2 on digit 0 held 9 edges.
    for (int k = 1; k <= 9; k++) begin
      tick(7'h24, 4'b0001, 1'b0, "lat");
      if (k == 8) ck("lat_before", 32'(out_valid), 32'd0);
    end
    ck("lat_valid", 32'(out_valid), 32'd1);
    ck("lat_value", 32'(out_value), 32'h0002);
    ck("lat_blank", 32'(out_blank), 32'hE);
    ck("lat_error", 32'(out_error), 32'h0);

    // Scan all digits with ready held high.
    hold(7'h79, 4'b0001, 1'b1, 10, "scan0");
    hold(7'h30, 4'b0010, 1'b1, 10, "scan1");
    hold(7'h08, 4'b0100, 1'b1, 10, "scan2");
    hold(7'h0E, 4'b1000, 1'b1, 10, "scan3");
    ck("scan_value", 32'(out_value), 32'hFA31);
    ck("scan_blank", 32'(out_blank), 32'h0);

    // Glitch inside a run prevents the commit.
    do_reset("glitch");
    hold(7'h30, 4'b0010, 1'b0, 7, "gl_a");
    hold(7'h31, 4'b0010, 1'b0, 1, "gl_b");
    hold(7'h30, 4'b0010, 1'b0, 7, "gl_c");
    ck("gl_novalid", 32'(out_valid), 32'd0);
    hold(7'h31, 4'b0010, 1'b0, 1, "gl_d");
    hold(7'h30, 4'b0010, 1'b0, 9, "gl_e");
    ck("gl_valid", 32'(out_valid), 32'd1);
    ck("gl_value", 32'(out_value), 32'h0030);
    hold(7'h30, 4'b0010, 1'b1, 1, "gl_acc");

    // Invalid pattern flags an error; multi-hot select never commits.
    hold(7'h55, 4'b0100, 1'b0, 9, "err");
    ck("err_flag", 32'(out_error), 32'h4);
    ck("err_nib2", 32'(out_value[11:8]), 32'h0);
    hold(7'h55, 4'b0100, 1'b1, 1, "err_acc");
    hold(7'h24, 4'b0011, 1'b0, 20, "multi");
    ck("multi_novalid", 32'(out_valid), 32'd0);

    // Outputs stay frozen while the consumer stalls.
    hold(7'h30, 4'b0001, 1'b0, 9, "frz_a");
    ck("frz_first", 32'(out_value), 32'h0033);
    hold(7'h12, 4'b0001, 1'b0, 10, "frz_b");
    ck("frz_held", 32'(out_value), 32'h0033);
    ck("frz_valid", 32'(out_valid), 32'd1);
    hold(7'h12, 4'b0001, 1'b1, 1, "frz_acc");
    ck("frz_gap", 32'(out_valid), 32'd0);
    hold(7'h12, 4'b0001, 1'b0, 1, "frz_next");
    ck("frz_new", 32'(out_value), 32'h0035);
    hold(7'h12, 4'b0001, 1'b1, 1, "frz_acc2");

    // Identical re-commit produces no new word.
    hold(7'h12, 4'b0000, 1'b0, 2, "same_gap");
    hold(7'h12, 4'b0001, 1'b0, 20, "same");
    ck("same_novalid", 32'(out_valid), 32'd0);

    // Random display traffic.
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 9) == 0) rd = 4'($urandom_range(0, 15));
      else rd = 4'(1 << $urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: rs = 7'h7F;
        1: rs = 7'($urandom_range(0, 127));
        default: rs = glyph[$urandom_range(0, 15)];
      endcase
      rl = int'($urandom_range(1, 12));
      for (int k = 0; k < rl; k++) tick(rs, rd, 1'($urandom_range(0, 1)), "rnd");
      $display("rnd %0d seg_n=%02h dig_en=%b cycles=%0d valid=%0d value=%04h",
               t, rs, rd, rl, out_valid, out_value);
    end

    // Reset while a word is pending.
    do_reset("pre");
    hold(7'h40, 4'b1000, 1'b0, 9, "mid");
    ck("mid_valid", 32'(out_valid), 32'd1);
    ck("mid_blank", 32'(out_blank), 32'h7);
    do_reset("mid");
    hold(7'h7F, 4'b0000, 1'b0, 3, "post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
